mem_byte_ctrl: RTL

//   CPU-side memory controller between the core's load/store/fetch logic and the

---
 rtl/mem_byte_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_byte_ctrl.sv
// -----------------------------------------------------------------------------
// mem_byte_ctrl
//
// CPU-side memory controller sitting between the core's load/store/fetch logic
// and the byte-wide system memory bus. A single 1/2/4-byte request becomes a
// run of consecutive little-endian byte accesses. Reads are pipelined against
// the one-cycle synchronous RAM latency (a new address goes out every cycle
// while the previous one's data comes back). Load results are assembled and
// optionally sign-extended.
//
// Ports
//   clk_in      clock, all state updates on the rising edge
//   rst_in      synchronous active-high reset
//   rdy_in      bus ready; 0 means the system is paused and HCI owns the bus
//   req_valid   request present
//   req_ready   controller idle; a request is accepted when valid && ready
//   req_wr      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10/11 word
//   req_sext    loads: sign-extend (1) or zero-extend (0)
//   req_addr    start byte address, any alignment
//   req_wdata   store data, byte i = req_wdata[8i+7:8i]
//   resp_valid  completion pulse
//   resp_rdata  load result (0 for stores), valid with resp_valid
//   mem_a       bus byte address (registered)
//   mem_dout    bus write data (registered)
//   mem_wr      bus write strobe (registered)
//   mem_din     bus read data, valid one cycle after mem_a is presented
// -----------------------------------------------------------------------------
module mem_byte_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    input  logic [7:0]            mem_din
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            len_q;
    logic                  sext_q;
    // issue_q: next byte index to put on the bus.
    // cap_q:   bytes completed (captured for reads, committed for writes).
    logic [2:0]            issue_q;
    logic [2:0]            cap_q;
    // Two-stage read pipeline tracking: addr_live_q marks that mem_a in the
    // current cycle is a genuine issue; data_live_q marks that mem_din in the
    // current cycle answers such an issue.
    logic                  addr_live_q;
    logic                  data_live_q;
    // Set by a paused edge; the next ready edge restarts issue at cap_q.
    logic                  paused_q;
    logic [31:0]           rbuf_q;

    logic [2:0]            req_len;
    logic [2:0]            next_idx;
    logic [2:0]            cap_inc;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [7:0]            next_byte;
    logic [31:0]           merged;
    logic [31:0]           ext_rdata;

    assign req_ready = (state_q == StIdle) && rdy_in && !rst_in;

    always_comb begin
        case (req_size)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    // After a pause, everything not yet completed is re-issued from cap_q.
    assign next_idx  = paused_q ? cap_q : issue_q;
    assign cap_inc   = cap_q + 3'd1;
    assign next_addr = addr_q + {{(ADDR_WIDTH-3){1'b0}}, next_idx};
    assign next_byte = wdata_q[{next_idx[1:0], 3'b000} +: 8];

    // Read buffer with the byte arriving this cycle merged in, so the final
    // capture and the response can be produced on the same edge.
    always_comb begin
        merged = rbuf_q;
        merged[{cap_q[1:0], 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        case (len_q)
            3'd1:    ext_rdata = {{24{sext_q & merged[7]}}, merged[7:0]};
            3'd2:    ext_rdata = {{16{sext_q & merged[15]}}, merged[15:0]};
            default: ext_rdata = merged;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            len_q       <= '0;
            sext_q      <= 1'b0;
            issue_q     <= '0;
            cap_q       <= '0;
            addr_live_q <= 1'b0;
            data_live_q <= 1'b0;
            paused_q    <= 1'b0;
            rbuf_q      <= '0;
            mem_a       <= '0;
            mem_dout    <= '0;
            mem_wr      <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
        end else if (!rdy_in) begin
            // Bus owned elsewhere: freeze everything, never drive a write.
            mem_wr   <= 1'b0;
            paused_q <= 1'b1;
        end else begin
            paused_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    mem_wr     <= 1'b0;
                    resp_valid <= 1'b0;
                    // req_ready is implied here (idle, ready, not in reset).
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        len_q       <= req_len;
                        sext_q      <= req_sext;
                        mem_a       <= req_addr;
                        issue_q     <= 3'd1;
                        cap_q       <= 3'd0;
                        rbuf_q      <= '0;
                        data_live_q <= 1'b0;
                        if (req_wr) begin
                            mem_dout    <= req_wdata[7:0];
                            mem_wr      <= 1'b1;
                            addr_live_q <= 1'b0;
                            state_q     <= StWrite;
                        end else begin
                            addr_live_q <= 1'b1;
                            state_q     <= StRead;
                        end
                    end
                end

                StRead: begin
                    if (paused_q) begin
                        // Anything in flight across the pause is untrusted.
                        mem_a       <= next_addr;
                        issue_q     <= cap_inc;
                        addr_live_q <= 1'b1;
                        data_live_q <= 1'b0;
                    end else begin
                        data_live_q <= addr_live_q;
                        if (data_live_q) begin
                            rbuf_q <= merged;
                            cap_q  <= cap_inc;
                            if (cap_inc == len_q) begin
                                state_q    <= StDone;
                                resp_valid <= 1'b1;
                                resp_rdata <= ext_rdata;
                            end
                        end
                        if (issue_q < len_q) begin
                            mem_a       <= next_addr;
                            issue_q     <= issue_q + 3'd1;
                            addr_live_q <= 1'b1;
                        end else begin
                            addr_live_q <= 1'b0;
                        end
                    end
                end

                StWrite: begin
                    if (paused_q) begin
                        // The strobe that overlapped the pause may have been
                        // lost; rewrite from the oldest uncommitted byte.
                        mem_a    <= next_addr;
                        mem_dout <= next_byte;
                        mem_wr   <= 1'b1;
                        issue_q  <= cap_inc;
                    end else begin
                        // The strobe presented this cycle met a ready bus.
                        cap_q <= cap_inc;
                        if (cap_inc == len_q) begin
                            mem_wr     <= 1'b0;
                            state_q    <= StDone;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_a    <= next_addr;
                            mem_dout <= next_byte;
                            mem_wr   <= 1'b1;
                            issue_q  <= issue_q + 3'd1;
                        end
                    end
                end

                StDone: begin
                    mem_wr     <= 1'b0;
                    resp_valid <= 1'b0;
                    state_q    <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
